// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the IF stage: fetch FSM encoding, default boot address and NOP word.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_REQ  = 2'd1,
        FS_KILL = 2'd2,
        FS_HOLD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

endpackage

// File: rtl/fetch_npc.sv
// Combinational next-PC calculator: sequential PC+4 and the ID-stage redirect target.
module fetch_npc
    import fetch_unit_pkg::*;
#(
    parameter int unsigned IM_AW = 32
) (
    input  logic [IM_AW-1:0] pc_i,
    input  logic [IM_AW-1:0] ifid_pc4_i,
    input  logic [15:0]      imm_i,
    input  logic [25:0]      jaddr_i,
    input  logic             jsel_i,
    output logic [IM_AW-1:0] pc4_o,
    output logic [IM_AW-1:0] target_o
);

    logic [IM_AW-1:0] br_off;
    logic [IM_AW-1:0] br_target;
    logic [IM_AW-1:0] j_target;

    always_comb begin
        pc4_o     = pc_i + IM_AW'(4);
        br_off    = {{(IM_AW-18){imm_i[15]}}, imm_i, 2'b00};
        br_target = ifid_pc4_i + br_off;
        j_target  = {ifid_pc4_i[IM_AW-1:IM_AW-4], jaddr_i, 2'b00};
        // Jump wins when both decode as taken.
        target_o  = jsel_i ? j_target : br_target;
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, runs the instruction-memory handshake and holds the IF/ID register.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned IM_AW    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             brSignal,
    input  logic [15:0]      Imm,
    input  logic             jSignal,
    input  logic [25:0]      JAddr,
    output logic             im_req,
    output logic [IM_AW-1:0] im_addr,
    input  logic             im_rdy,
    input  logic [31:0]      im_rdata,
    output logic [31:0]      IFID_instr,
    output logic [IM_AW-1:0] IFID_pc4,
    output logic             IFID_valid,
    output logic [IM_AW-1:0] PC
);

    fetch_state_e     state_q;
    logic [IM_AW-1:0] pc_q;
    logic [IM_AW-1:0] kill_addr_q;
    logic [31:0]      ifid_instr_q;
    logic [IM_AW-1:0] ifid_pc4_q;
    logic             ifid_valid_q;
    logic [31:0]      skid_instr_q;
    logic [IM_AW-1:0] skid_pc4_q;
    logic             im_req_q;

    logic             done;
    logic             redirect;
    logic [IM_AW-1:0] pc4;
    logic [IM_AW-1:0] target;

    fetch_npc #(
        .IM_AW (IM_AW)
    ) u_npc (
        .pc_i       (pc_q),
        .ifid_pc4_i (ifid_pc4_q),
        .imm_i      (Imm),
        .jaddr_i    (JAddr),
        .jsel_i     (jSignal),
        .pc4_o      (pc4),
        .target_o   (target)
    );

    always_comb begin
        done     = im_req_q && im_rdy;
        // Branch operands are not final under stall, so redirects wait.
        redirect = ifid_valid_q && !stall && (brSignal || jSignal);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FS_BOOT;
            pc_q         <= IM_AW'(RESET_PC);
            kill_addr_q  <= IM_AW'(RESET_PC);
            ifid_instr_q <= NOP_WORD;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
            skid_instr_q <= NOP_WORD;
            skid_pc4_q   <= '0;
            im_req_q     <= 1'b0;
        end else begin
            case (state_q)
                FS_BOOT: begin
                    state_q  <= FS_REQ;
                    im_req_q <= 1'b1;
                end
                FS_REQ: begin
                    if (redirect) begin
                        pc_q         <= target;
                        ifid_valid_q <= 1'b0;
                        if (!done) begin
                            // Memory still owes a word for the old address; drain it first.
                            kill_addr_q <= pc_q;
                            state_q     <= FS_KILL;
                        end
                    end else if (done) begin
                        pc_q <= pc4;
                        if (stall) begin
                            skid_instr_q <= im_rdata;
                            skid_pc4_q   <= pc4;
                            state_q      <= FS_HOLD;
                            im_req_q     <= 1'b0;
                        end else begin
                            ifid_instr_q <= im_rdata;
                            ifid_pc4_q   <= pc4;
                            ifid_valid_q <= 1'b1;
                        end
                    end else if (!stall) begin
                        ifid_valid_q <= 1'b0;
                    end
                end
                FS_KILL: begin
                    if (im_rdy) begin
                        state_q <= FS_REQ;
                    end
                end
                FS_HOLD: begin
                    if (redirect) begin
                        pc_q         <= target;
                        ifid_valid_q <= 1'b0;
                        state_q      <= FS_REQ;
                        im_req_q     <= 1'b1;
                    end else if (!stall) begin
                        ifid_instr_q <= skid_instr_q;
                        ifid_pc4_q   <= skid_pc4_q;
                        ifid_valid_q <= 1'b1;
                        state_q      <= FS_REQ;
                        im_req_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= FS_BOOT;
                    im_req_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        im_req     = im_req_q;
        im_addr    = (state_q == FS_KILL) ? kill_addr_q : pc_q;
        IFID_instr = ifid_instr_q;
        IFID_pc4   = ifid_pc4_q;
        IFID_valid = ifid_valid_q;
        PC         = pc_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory returns {16'hC0DE, addr[15:0]} so each word names its address.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        brSignal;
    logic [15:0] Imm;
    logic        jSignal;
    logic [25:0] JAddr;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_rdy;
    logic [31:0] im_rdata;
    logic [31:0] IFID_instr;
    logic [31:0] IFID_pc4;
    logic        IFID_valid;
    logic [31:0] PC;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit #(
        .RESET_PC (32'h0000_3000),
        .IM_AW    (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .brSignal   (brSignal),
        .Imm        (Imm),
        .jSignal    (jSignal),
        .JAddr      (JAddr),
        .im_req     (im_req),
        .im_addr    (im_addr),
        .im_rdy     (im_rdy),
        .im_rdata   (im_rdata),
        .IFID_instr (IFID_instr),
        .IFID_pc4   (IFID_pc4),
        .IFID_valid (IFID_valid),
        .PC         (PC)
    );

    assign im_rdata = {16'hC0DE, im_addr[15:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc4);
        chk({tag, ".valid"}, {31'd0, IFID_valid}, 32'd1);
        chk({tag, ".instr"}, IFID_instr, instr);
        chk({tag, ".pc4"}, IFID_pc4, pc4);
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; brSignal = 1'b0; jSignal = 1'b0;
        Imm = 16'h0; JAddr = 26'h0; im_rdy = 1'b1;

        // Reset held for three cycles.
        step(); step(); step();
        chk("rst.pc", PC, 32'h3000);
        chk("rst.req", {31'd0, im_req}, 32'd0);
        chk("rst.valid", {31'd0, IFID_valid}, 32'd0);
        chk("rst.instr", IFID_instr, 32'h0);
        chk("rst.pc4", IFID_pc4, 32'h0);
        rst = 1'b1;
        #1;
        chk("boot.req", {31'd0, im_req}, 32'd0);
        step();
        chk("req.req", {31'd0, im_req}, 32'd1);
        chk("req.addr", im_addr, 32'h3000);
        chk("req.valid", {31'd0, IFID_valid}, 32'd0);

        // Zero-wait stream.
        step(); chk_ifid("strA", 32'hC0DE3000, 32'h3004);
        step(); chk_ifid("strB", 32'hC0DE3004, 32'h3008);
        chk("strB.pc", PC, 32'h3008);

        // Taken branch with completion: 0x3008 + (-2 << 2) = 0x3000; word at 0x3008 dropped.
        brSignal = 1'b1; Imm = 16'hFFFE;
        step();
        brSignal = 1'b0;
        chk("br.valid", {31'd0, IFID_valid}, 32'd0);
        chk("br.addr", im_addr, 32'h3000);
        chk("br.instr", IFID_instr, 32'hC0DE3004);
        step(); chk_ifid("br.fetch", 32'hC0DE3000, 32'h3004);

        // Two wait states at 0x3004.
        im_rdy = 1'b0;
        step();
        chk("ws1.valid", {31'd0, IFID_valid}, 32'd0);
        chk("ws1.addr", im_addr, 32'h3004);
        step();
        chk("ws2.valid", {31'd0, IFID_valid}, 32'd0);
        chk("ws2.addr", im_addr, 32'h3004);
        im_rdy = 1'b1;
        step(); chk_ifid("ws.B", 32'hC0DE3004, 32'h3008);

        // Jump: {0x0, 0xC10, 00} = 0x3040, priority over a simultaneous branch.
        jSignal = 1'b1; brSignal = 1'b1; JAddr = 26'h0000C10; Imm = 16'h0001;
        step();
        jSignal = 1'b0; brSignal = 1'b0;
        chk("j.valid", {31'd0, IFID_valid}, 32'd0);
        chk("j.addr", im_addr, 32'h3040);
        step(); chk_ifid("j.fetch", 32'hC0DE3040, 32'h3044);

        // Redirect while fetch pending: target 0x3044 + 16 = 0x3054.
        im_rdy = 1'b0; brSignal = 1'b1; Imm = 16'h0004;
        step();
        brSignal = 1'b0;
        chk("kill.addr", im_addr, 32'h3044);
        chk("kill.req", {31'd0, im_req}, 32'd1);
        chk("kill.pc", PC, 32'h3054);
        chk("kill.valid", {31'd0, IFID_valid}, 32'd0);
        step();
        chk("kill.hold", im_addr, 32'h3044);
        im_rdy = 1'b1;
        step();
        chk("kill.drop", {31'd0, IFID_valid}, 32'd0);
        chk("kill.target", im_addr, 32'h3054);
        step(); chk_ifid("kill.fetch", 32'hC0DE3054, 32'h3058);

        // Stall while a word returns; branch under stall must be ignored.
        stall = 1'b1; brSignal = 1'b1; Imm = 16'h0100;
        step();
        chk_ifid("st1", 32'hC0DE3054, 32'h3058);
        chk("st1.req", {31'd0, im_req}, 32'd0);
        chk("st1.pc", PC, 32'h305C);
        step();
        chk_ifid("st2", 32'hC0DE3054, 32'h3058);
        step();
        chk_ifid("st3", 32'hC0DE3054, 32'h3058);
        chk("st3.req", {31'd0, im_req}, 32'd0);
        stall = 1'b0; brSignal = 1'b0;
        step();
        chk_ifid("st.drain", 32'hC0DE3058, 32'h305C);
        chk("st.addr", im_addr, 32'h305C);
        step(); chk_ifid("st.next", 32'hC0DE305C, 32'h3060);

        // Reset pulse in the middle of a KILL.
        im_rdy = 1'b0; brSignal = 1'b1; Imm = 16'h0000;
        step();
        brSignal = 1'b0;
        chk("rk.addr", im_addr, 32'h3060);
        #2 rst = 1'b0;
        #1;
        chk("rk.pc", PC, 32'h3000);
        chk("rk.valid", {31'd0, IFID_valid}, 32'd0);
        chk("rk.req", {31'd0, im_req}, 32'd0);
        im_rdy = 1'b1;
        step();
        rst = 1'b1;
        #1;
        chk("rk.boot", {31'd0, im_req}, 32'd0);
        step();
        chk("rk.req2", {31'd0, im_req}, 32'd1);
        chk("rk.addr2", im_addr, 32'h3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
